// File: rtl/proc_core_p.sv
// Multi-cycle accumulator processor core with req/ack instruction and data memory ports.
// Sequence per instruction: FETCH (held until im_ack) -> EXEC -> optional MEM (held until dm_ack).
module proc_core_p #(
    parameter int DW   = 16,
    parameter int AW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          im_req,
    output logic [AW-1:0] im_addr,
    input  logic [15:0]   im_rdata,
    input  logic          im_ack,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    input  logic          dm_ack,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] ac_out,
    output logic          end_process
);
    localparam int RW = $clog2(NREG);

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MVR  = 4'h2;
    localparam logic [3:0] OP_MVA  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_INC  = 4'h6;
    localparam logic [3:0] OP_LDM  = 4'h7;
    localparam logic [3:0] OP_STM  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_ac;
    logic [15:0]   r_ir;
    logic          r_z;
    logic [DW-1:0] r_regs [NREG];

    logic [3:0]    w_op;
    logic [RW-1:0] w_rs;
    logic [DW-1:0] w_rs_val;
    logic [DW-1:0] w_imm_dw;
    logic [AW-1:0] w_imm_aw;
    logic [DW-1:0] w_add;
    logic [DW-1:0] w_sub;
    logic [DW-1:0] w_inc;

    assign w_op     = r_ir[15:12];
    // Masking keeps only the register-select bits that exist for this NREG.
    assign w_rs     = RW'(r_ir[11:8] & 4'(NREG - 1));
    assign w_rs_val = r_regs[w_rs];
    assign w_imm_dw = DW'(r_ir[7:0]);
    assign w_imm_aw = AW'(r_ir[7:0]);
    assign w_add    = r_ac + w_rs_val;
    assign w_sub    = r_ac - w_rs_val;
    assign w_inc    = w_rs_val + DW'(1);

    assign im_addr  = r_pc;
    assign pc_out   = r_pc;
    assign ac_out   = r_ac;
    assign dm_wdata = r_ac;
    assign dm_addr  = AW'(w_rs_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Requests decode straight from the state register so reset drops them immediately.
    always_comb begin
        w_next      = r_state;
        im_req      = 1'b0;
        dm_req      = 1'b0;
        dm_we       = 1'b0;
        end_process = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                im_req = 1'b1;
                if (im_ack) w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_op == OP_LDM || w_op == OP_STM) w_next = S_MEM;
                else if (w_op == OP_HALT)             w_next = S_HALT;
                else                                  w_next = S_FETCH;
            end
            S_MEM: begin
                dm_req = 1'b1;
                dm_we  = (w_op == OP_STM);
                if (dm_ack) w_next = S_FETCH;
            end
            S_HALT: begin
                end_process = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
            r_ac <= '0;
            r_ir <= '0;
            r_z  <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (im_ack) begin
                        r_ir <= im_rdata;
                        r_pc <= r_pc + AW'(1);
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        OP_LDI: begin
                            r_ac <= w_imm_dw;
                            r_z  <= (w_imm_dw == '0);
                        end
                        OP_MVR: r_regs[w_rs] <= r_ac;
                        OP_MVA: begin
                            r_ac <= w_rs_val;
                            r_z  <= (w_rs_val == '0);
                        end
                        OP_ADD: begin
                            r_ac <= w_add;
                            r_z  <= (w_add == '0);
                        end
                        OP_SUB: begin
                            r_ac <= w_sub;
                            r_z  <= (w_sub == '0);
                        end
                        OP_INC: r_regs[w_rs] <= w_inc;
                        OP_JMP: r_pc <= w_imm_aw;
                        OP_JZ: begin
                            if (r_z) r_pc <= w_imm_aw;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dm_ack && w_op == OP_LDM) begin
                        r_ac <= dm_rdata;
                        r_z  <= (dm_rdata == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_core_p.sv
// Directed bench for proc_core_p: a 16-bit default instance with wait-state memory models and
// an 8-bit/NREG=4 instance for width-dependent wrap behaviour; fetches and data accesses are scoreboarded.
module tb_proc_core_p;
    localparam int DW = 16;
    localparam int AW = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ac;
    } fexp_t;

    typedef struct {
        logic [31:0] we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic run = 1'b0;
    logic run8 = 1'b0;

    logic          im_req, im_ack, dm_req, dm_we, dm_ack, end_process;
    logic [AW-1:0] im_addr, dm_addr, pc_out;
    logic [15:0]   im_rdata;
    logic [DW-1:0] dm_wdata, dm_rdata, ac_out;

    logic       im_req8, im_ack8, dm_req8, dm_we8, dm_ack8, end_process8;
    logic [7:0] im_addr8, dm_addr8, pc_out8, dm_wdata8, dm_rdata8, ac_out8;
    logic [15:0] im_rdata8;

    logic [15:0]   prog  [256];
    logic [15:0]   prog8 [256];
    logic [DW-1:0] dmem  [256];

    int   im_lat = 0;
    int   dm_lat = 0;
    int   icnt = 0;
    int   dcnt = 0;
    logic ack_force = 1'b0;
    logic poke_en = 1'b0;
    logic [7:0]    poke_addr = '0;
    logic [DW-1:0] poke_dat = '0;

    int nvec = 0;
    int nfail = 0;

    fexp_t fq[$];
    fexp_t fq8[$];
    dexp_t dq[$];

    proc_core_p #(.DW(16), .AW(16), .NREG(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_ack(im_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .pc_out(pc_out), .ac_out(ac_out), .end_process(end_process)
    );

    proc_core_p #(.DW(8), .AW(8), .NREG(4)) dut8 (
        .clk(clk), .rst(rst), .run(run8),
        .im_req(im_req8), .im_addr(im_addr8), .im_rdata(im_rdata8), .im_ack(im_ack8),
        .dm_req(dm_req8), .dm_we(dm_we8), .dm_addr(dm_addr8), .dm_wdata(dm_wdata8),
        .dm_rdata(dm_rdata8), .dm_ack(dm_ack8),
        .pc_out(pc_out8), .ac_out(ac_out8), .end_process(end_process8)
    );

    // Memory models: ack after a programmable number of wait cycles (0 = same cycle).
    assign im_ack    = (im_req && icnt >= im_lat) || ack_force;
    assign im_rdata  = prog[im_addr[7:0]];
    assign dm_ack    = (dm_req && dcnt >= dm_lat) || ack_force;
    assign dm_rdata  = dmem[dm_addr[7:0]];
    assign im_ack8   = im_req8;
    assign im_rdata8 = prog8[im_addr8];
    assign dm_ack8   = dm_req8;
    assign dm_rdata8 = 8'h00;

    always @(posedge clk) begin
        icnt <= (im_req && !im_ack) ? icnt + 1 : 0;
        dcnt <= (dm_req && !dm_ack) ? dcnt + 1 : 0;
        if (dm_req && dm_ack && dm_we) dmem[dm_addr[7:0]] <= dm_wdata;
        if (poke_en) dmem[poke_addr] <= poke_dat;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rs, input logic [7:0] imm);
        return {op, rs, imm};
    endfunction

    task automatic fx(input logic [31:0] a, input logic [31:0] ac);
        fexp_t e;
        e.addr = a;
        e.ac   = ac;
        fq.push_back(e);
    endtask

    task automatic fx8(input logic [31:0] a, input logic [31:0] ac);
        fexp_t e;
        e.addr = a;
        e.ac   = ac;
        fq8.push_back(e);
    endtask

    task automatic dx(input logic [31:0] we, input logic [31:0] a, input logic [31:0] wd);
        dexp_t e;
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        dq.push_back(e);
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    logic [31:0] lt_we, lt_addr, lt_wdata;
    int dreq_len = 0;
    always @(negedge clk) begin
        fexp_t f;
        dexp_t d;
        if (!rst) begin
            check("req_exclusive", {31'd0, im_req & dm_req}, 32'd0);
            if (im_req && im_ack) begin
                if (fq.size() == 0) check("fetch_extra", fq.size(), 32'd1);
                else begin
                    f = fq.pop_front();
                    check("fetch_addr", im_addr, f.addr);
                    check("fetch_ac", ac_out, f.ac);
                end
            end
            if (dm_req) begin
                if (dreq_len == 0) begin
                    lt_we = dm_we; lt_addr = dm_addr; lt_wdata = dm_wdata;
                end else begin
                    check("dm_we_stable", dm_we, lt_we);
                    check("dm_addr_stable", dm_addr, lt_addr);
                    check("dm_wdata_stable", dm_wdata, lt_wdata);
                end
                dreq_len++;
                if (dm_ack) begin
                    check("dm_req_len", dreq_len, dm_lat + 1);
                    if (dq.size() == 0) check("dm_extra", dq.size(), 32'd1);
                    else begin
                        d = dq.pop_front();
                        check("dm_we", dm_we, d.we);
                        check("dm_addr", dm_addr, d.addr);
                        check("dm_wdata", dm_wdata, d.wdata);
                    end
                end
            end
            if (im_req8 && im_ack8) begin
                if (fq8.size() == 0) check("fetch8_extra", fq8.size(), 32'd1);
                else begin
                    f = fq8.pop_front();
                    check("fetch8_addr", im_addr8, f.addr);
                    check("fetch8_ac", ac_out8, f.ac);
                end
            end
        end
        if (!dm_req) dreq_len = 0;
    end

    task automatic do_reset();
        rst  = 1'b1;
        run  = 1'b0;
        run8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts the core and returns the number of cycles until end_process is seen.
    task automatic run_prog(input string tag, input int budget, output int cycles);
        @(negedge clk);
        run = 1'b1;
        cycles = 0;
        while (!end_process && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, {31'd0, end_process}, 32'd1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) begin
            prog[i]  = 16'h0000;
            prog8[i] = 16'h0000;
        end

        // Reset and idle with run low.
        do_reset();
        check("rst_pc", pc_out, 32'h0);
        check("rst_ac", ac_out, 32'h0);
        check("rst_end", {31'd0, end_process}, 32'd0);
        check("rst_dm_we", {31'd0, dm_we}, 32'd0);
        check("rst_im_addr", im_addr, 32'h0);
        check("rst_dm_wdata", dm_wdata, 32'h0);
        repeat (10) begin
            @(negedge clk);
            check("idle_noreq", {30'd0, im_req, dm_req}, 32'd0);
        end

        // Arithmetic, z flag, taken and untaken JZ, zero-wait 2-cycle instructions.
        prog[0]     = ins(4'h1, 4'h0, 8'h05);
        prog[1]     = ins(4'h2, 4'h1, 8'h00);
        prog[2]     = ins(4'h5, 4'h1, 8'h00);
        prog[3]     = ins(4'hA, 4'h0, 8'h10);
        prog[8'h10] = ins(4'h4, 4'h1, 8'h00);
        prog[8'h11] = ins(4'hA, 4'h0, 8'h20);
        prog[8'h12] = ins(4'hF, 4'h0, 8'h00);
        fx(0, 0); fx(1, 5); fx(2, 5); fx(3, 0); fx(32'h10, 0); fx(32'h11, 5); fx(32'h12, 5);
        run_prog("t2_halt", 100, cyc);
        check("t2_cycles", cyc, 32'd15);
        check("t2_ac", ac_out, 32'h5);
        check("t2_pc", pc_out, 32'h13);

        // Halted core ignores run.
        repeat (10) begin
            @(negedge clk);
            check("halt_noreq", {30'd0, im_req, dm_req}, 32'd0);
            check("halt_end", {31'd0, end_process}, 32'd1);
        end

        // Loads and stores with three data wait states.
        do_reset();
        poke_addr = 8'h41; poke_dat = 16'h1234; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
        dm_lat = 3;
        prog[0]  = ins(4'h1, 4'h0, 8'h41);
        prog[1]  = ins(4'h2, 4'h2, 8'h00);
        prog[2]  = ins(4'h7, 4'h2, 8'h00);
        prog[3]  = ins(4'h2, 4'h4, 8'h00);
        prog[4]  = ins(4'h1, 4'h0, 8'h40);
        prog[5]  = ins(4'h2, 4'h2, 8'h00);
        prog[6]  = ins(4'h3, 4'h4, 8'h00);
        prog[7]  = ins(4'h8, 4'h2, 8'h00);
        prog[8]  = ins(4'h1, 4'h0, 8'h00);
        prog[9]  = ins(4'h7, 4'h2, 8'h00);
        prog[10] = ins(4'hF, 4'h0, 8'h00);
        fx(0, 0); fx(1, 32'h41); fx(2, 32'h41); fx(3, 32'h1234); fx(4, 32'h1234);
        fx(5, 32'h40); fx(6, 32'h40); fx(7, 32'h1234); fx(8, 32'h1234); fx(9, 0); fx(10, 32'h1234);
        dx(0, 32'h41, 32'h41); dx(1, 32'h40, 32'h1234); dx(0, 32'h40, 32'h0);
        run_prog("t3_halt", 200, cyc);
        check("t3_cycles", cyc, 32'd35);
        check("t3_ac", ac_out, 32'h1234);
        check("t3_dmem40", dmem[8'h40], 32'h1234);

        // 8-bit instance: INC wraps 0xFF->0x00, pc wraps 0xFF->0x00, JZ both ways.
        do_reset();
        prog8[8'h00] = ins(4'hA, 4'h0, 8'h20);
        prog8[8'h01] = ins(4'h1, 4'h0, 8'hFF);
        prog8[8'h02] = ins(4'h2, 4'h5, 8'h00);
        prog8[8'h03] = ins(4'h6, 4'h1, 8'h00);
        prog8[8'h04] = ins(4'h3, 4'h1, 8'h00);
        prog8[8'h05] = ins(4'h9, 4'h0, 8'hFE);
        prog8[8'hFE] = ins(4'h0, 4'h0, 8'h00);
        prog8[8'hFF] = ins(4'h0, 4'h0, 8'h00);
        prog8[8'h20] = ins(4'hF, 4'h0, 8'h00);
        fx8(0, 0); fx8(1, 0); fx8(2, 32'hFF); fx8(3, 32'hFF); fx8(4, 32'hFF);
        fx8(5, 0); fx8(32'hFE, 0); fx8(32'hFF, 0); fx8(0, 0); fx8(32'h20, 0);
        @(negedge clk);
        run8 = 1'b1;
        cyc = 0;
        while (!end_process8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("t8_halt", {31'd0, end_process8}, 32'd1);
        check("t8_cycles", cyc, 32'd21);
        check("t8_pc", pc_out8, 32'h21);
        check("t8_ac", ac_out8, 32'h0);
        check("t8_dm_we", {31'd0, dm_we8}, 32'd0);
        check("t8_dm_addr", dm_addr8, 32'h0);
        check("t8_dm_wdata", dm_wdata8, 32'h0);

        // Reset in the middle of a data access, then restart.
        do_reset();
        dm_lat = 20;
        prog[0] = ins(4'h1, 4'h0, 8'h40);
        prog[1] = ins(4'h2, 4'h2, 8'h00);
        prog[2] = ins(4'h7, 4'h2, 8'h00);
        prog[3] = ins(4'hF, 4'h0, 8'h00);
        fx(0, 0); fx(1, 32'h40); fx(2, 32'h40);
        @(negedge clk);
        run = 1'b1;
        cyc = 0;
        while (!dm_req && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_dm_req_seen", {31'd0, dm_req}, 32'd1);
        #1;
        rst = 1'b1;
        run = 1'b0;
        #1;
        check("t5_rst_dm_req", {31'd0, dm_req}, 32'd0);
        check("t5_rst_im_req", {31'd0, im_req}, 32'd0);
        check("t5_rst_pc", pc_out, 32'h0);
        check("t5_rst_ac", ac_out, 32'h0);
        @(negedge clk);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        check("t5_ack_in_rst_pc", pc_out, 32'h0);
        check("t5_ack_in_rst_ir", {31'd0, im_req}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        check("t5_stray_ack_pc", pc_out, 32'h0);
        check("t5_stray_ack_req", {30'd0, im_req, dm_req}, 32'd0);
        im_lat = 1;
        dm_lat = 0;
        fx(0, 0); fx(1, 32'h40); fx(2, 32'h40); fx(3, 32'h1234);
        dx(0, 32'h40, 32'h40);
        run_prog("t5_halt", 100, cyc);
        check("t5_cycles", cyc, 32'd14);
        check("t5_ac", ac_out, 32'h1234);
        check("t5_pc", pc_out, 32'h4);

        @(negedge clk);
        check("fq_drained", fq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);
        check("fq8_drained", fq8.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
